// File: rtl/piradip_axis_sync_fifo_pkg.sv
// Shared defaults for the piradip AXIS FIFO slice.
// Instantiating designs normally override WIDTH/DEPTH with their own stream
// widths. These values are only the standalone defaults.
package piradip_axis_sync_fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 32;
    localparam int FIFO_DEF_DEPTH = 16;

endpackage

// File: rtl/piradip_fifo_dpram.sv
// Simple dual-port storage for the AXIS FIFO.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (asynchronous)
// Contents are intentionally not reset.
module piradip_fifo_dpram
    import piradip_axis_sync_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH + 1,
    parameter int DEPTH = FIFO_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/piradip_axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO (tdata + tlast), first-word-fall-through.
// Ports:
//   aclk, aresetn                  - clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast - write-side AXIS
//   m_tdata/m_tvalid/m_tready/m_tlast - read-side AXIS (head entry shown)
// s_tready comes from a register loaded with the next count, so it never
// depends on m_tready and stays low while reset is asserted.
module piradip_axis_sync_fifo
    import piradip_axis_sync_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_q, rdy_d;
    logic          push, pop;
    logic [WIDTH:0] rd_word;

    assign m_tvalid = (count_q != '0);
    assign s_tready = rdy_q;
    assign push     = s_tvalid & rdy_q;
    assign pop      = m_tvalid & m_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Looking ahead at the next count lets ready reassert the cycle
        // after a pop from full, without a combinational m_tready path.
        rdy_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    piradip_fifo_dpram #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (aclk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign m_tlast = rd_word[WIDTH];
    assign m_tdata = rd_word[WIDTH-1:0];

endmodule

// File: tb/tb_piradip_axis_sync_fifo.sv
module tb_piradip_axis_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             aclk;
    logic             aresetn;
    logic [WIDTH-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    logic [WIDTH:0] sb [$];

    piradip_axis_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, advance, then
    // confirm a stalled head entry held its value.
    task automatic step(output logic pushed);
        logic           psh, pp, stall;
        logic [WIDTH:0] held, exp;
        psh   = s_tvalid & s_tready;
        pp    = m_tvalid & m_tready;
        stall = m_tvalid & ~m_tready;
        held  = {m_tlast, m_tdata};
        if (pp) begin
            n_pops++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                chk("sb_word", 64'({m_tlast, m_tdata}), 64'(exp));
            end
        end
        if (psh) sb.push_back({s_tlast, s_tdata});
        @(posedge aclk);
        #1;
        if (stall) chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, held}));
        pushed = psh;
    endtask

    initial begin
        logic p;
        int   n, cyc;
        logic got17;

        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // reset
        repeat (5) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rel_s_tready", 64'(s_tready), 64'd1);
        chk("rel_m_tvalid", 64'(m_tvalid), 64'd0);

        // two words streaming through
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5B6A5B6;
        s_tlast  = 1'b0;
        #1;
        chk("no_bypass", 64'(m_tvalid), 64'd0);
        step(p);
        chk("w1_valid", 64'(m_tvalid), 64'd1);
        chk("w1_data", 64'(m_tdata), 64'hA5B6A5B6);
        chk("w1_last", 64'(m_tlast), 64'd0);
        s_tdata = 32'hBCBCBCBC;
        s_tlast = 1'b1;
        step(p);
        s_tvalid = 1'b0;
        chk("w2_data", 64'(m_tdata), 64'hBCBCBCBC);
        chk("w2_last", 64'(m_tlast), 64'd1);
        step(p);
        chk("w2_empty", 64'(m_tvalid), 64'd0);

        // fill to full, reject a 17th, then drain
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            s_tlast  = (i == DEPTH - 1);
            step(p);
            chk("fill_accept", 64'(p), 64'd1);
        end
        chk("full_s_tready", 64'(s_tready), 64'd0);
        chk("full_m_tvalid", 64'(m_tvalid), 64'd1);
        s_tdata = 32'd16;
        s_tlast = 1'b0;
        repeat (3) begin
            step(p);
            chk("full_reject", 64'(p), 64'd0);
        end
        chk("full_head", 64'(m_tdata), 64'd0);
        m_tready = 1'b1;
        got17 = 1'b0;
        cyc   = 0;
        while ((sb.size() != 0 || !got17 || m_tvalid) && cyc < 60) begin
            step(p);
            if (cyc == 0) chk("ready_reassert", 64'(s_tready), 64'd1);
            if (p) begin
                got17    = 1'b1;
                s_tvalid = 1'b0;
            end
            cyc++;
        end
        chk("drain_done", 64'({got17, m_tvalid, 32'(sb.size())}), 64'({1'b1, 1'b0, 32'd0}));

        // steady state at count 4 with simultaneous push/pop, wrapping pointers
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(100 + i);
            s_tlast  = 1'b0;
            step(p);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 32'(104 + i);
            s_tlast = (i % 5 == 4);
            step(p);
            chk("sim_push", 64'(p), 64'd1);
            chk("sim_flags", 64'({m_tvalid, s_tready}), 64'b11);
        end
        chk("sim_count4", 64'(sb.size()), 64'd4);
        s_tvalid = 1'b0;
        cyc = 0;
        while (m_tvalid && cyc < 20) begin
            step(p);
            cyc++;
        end
        chk("sim_drained", 64'({m_tvalid, 32'(sb.size())}), 64'd0);

        // random backpressure over 100 words
        n_pops = 0;
        n      = 0;
        cyc    = 0;
        s_tvalid = 1'b1;
        while (n < 100 && cyc < 2000) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = 32'(1000 + n);
            s_tlast  = (n % 8 == 7);
            step(p);
            if (p) n++;
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        cyc = 0;
        while (m_tvalid && cyc < 40) begin
            step(p);
            cyc++;
        end
        chk("bp_in_count", 64'(n), 64'd100);
        chk("bp_out_count", 64'(n_pops), 64'd100);

        // reset with 7 words queued
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(200 + i);
            s_tlast  = 1'b0;
            step(p);
        end
        s_tvalid = 1'b0;
        chk("pre_rst_valid", 64'(m_tvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_ready", 64'(s_tready), 64'd0);
        sb.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_flags", 64'({s_tready, m_tvalid}), 64'b10);
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEADBEEF;
        s_tlast  = 1'b1;
        step(p);
        s_tvalid = 1'b0;
        chk("post_rst_word", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b1, 32'hDEADBEEF}));
        m_tready = 1'b1;
        step(p);
        chk("post_rst_empty", 64'(m_tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
